// File: rtl/spi_phy_pkg.sv
// rtl/spi_phy_pkg.sv - shared types and constants for the SPI transmit PHY
// Purpose: SPI mode and FSM state enums, synchroniser depth and the
//          default idle word used when the transmit FIFO runs dry.
// Ports:   none (package).
package spi_phy_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,  // CPOL=0 CPHA=0
    MODE1 = 2'd1,  // CPOL=0 CPHA=1
    MODE2 = 2'd2,  // CPOL=1 CPHA=0
    MODE3 = 2'd3   // CPOL=1 CPHA=1
  } spi_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  localparam int SYNC_STAGES = 2;

  // All-ones word of data_w bits, built bitwise so data_w=32 needs no
  // out-of-range shift.
  function automatic logic [31:0] default_idle_word(input int data_w);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < data_w) w[i] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// rtl/spi_tx_fifo.sv - synchronous word FIFO feeding the SPI transmit shifter
// Purpose: DEPTH-entry (power of two) FIFO with a valid/ready write side,
//          a read-enable pop side showing the head word, and a level output.
// Ports:   i_clock, i_rst      clock, synchronous active-high reset
//          i_wr_data/valid     write word and its valid
//          o_wr_ready          not full (from registered level)
//          i_rd_en             pop request (ignored when empty)
//          o_rd_data           head word
//          o_empty, o_level    empty flag, words held
module spi_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     i_clock,
  input  logic                     i_rst,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_wr_valid,
  output logic                     o_wr_ready,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  assign w_full     = (r_level == LW'(DEPTH));
  assign o_empty    = (r_level == '0);
  assign o_wr_ready = ~w_full;
  assign o_level    = r_level;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign w_push     = i_wr_valid & ~w_full;
  assign w_pop      = i_rd_en & ~o_empty;

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
  // the natural binary wrap the ring wrap.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/spi_tx_word_phy.sv
// rtl/spi_tx_word_phy.sv - SPI slave transmit PHY, MSB-first words on miso
// Purpose: oversamples sck/cs_n, runs the IDLE/SHIFT machine and shifts
//          FIFO words out on miso in any CPOL/CPHA mode.
//          Optional macro SPI_TX_EDGE_CNT_EN adds trigger_cnt[23:0].
// Ports:   clock, rst          system clock, synchronous active-high reset
//          sck, cs_n           asynchronous SPI pins
//          miso, miso_oe       registered serial data, output enable
//          tx_data/valid/ready host word push handshake
//          fifo_level          words buffered
//          word_done, underrun single-cycle status pulses
//          idle                synchronised cs_n
//          trigger_cnt         shift-edge count (SPI_TX_EDGE_CNT_EN only)
module spi_tx_word_phy
  import spi_phy_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              DEPTH     = 4,
  parameter int              CPOL      = 0,
  parameter int              CPHA      = 0,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(default_idle_word(DATA_W))
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   sck,
  input  logic                   cs_n,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic [DATA_W-1:0]      tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   word_done,
  output logic                   underrun,
  output logic                   idle
`ifdef SPI_TX_EDGE_CNT_EN
  ,
  output logic [23:0]            trigger_cnt
`endif
);

  localparam int          CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam spi_mode_e   MODE     = spi_mode_e'({(CPOL != 0), (CPHA != 0)});
  localparam logic        CPOL_BIT = (MODE == MODE2) || (MODE == MODE3);
  localparam logic        CPHA_BIT = (MODE == MODE1) || (MODE == MODE3);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  spi_state_e        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_cnt_nxt;
  logic              r_first, w_first_nxt;
  logic              r_word_done, w_word_done;
  logic              r_underrun;
  logic              w_load, w_pop, w_underrun;

  logic              w_sck_s, w_cs_s;
  logic              w_rise, w_fall, w_lead, w_trail, w_shift_edge;
  logic              w_cs_fall, w_cs_rise;
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_fifo_empty;

  spi_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clock    (clock),
    .i_rst      (rst),
    .i_wr_data  (tx_data),
    .i_wr_valid (tx_valid),
    .o_wr_ready (tx_ready),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_empty    (w_fifo_empty),
    .o_level    (fifo_level)
  );

  // sck resets to its idle level so leaving reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_sck_sync <= {SYNC_STAGES{CPOL_BIT}};
      r_sck_d    <= CPOL_BIT;
      r_cs_sync  <= '1;
      r_cs_d     <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign w_sck_s      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s       = r_cs_sync[SYNC_STAGES-1];
  assign w_rise       = w_sck_s & ~r_sck_d;
  assign w_fall       = ~w_sck_s & r_sck_d;
  assign w_lead       = CPOL_BIT ? w_fall : w_rise;
  assign w_trail      = CPOL_BIT ? w_rise : w_fall;
  assign w_shift_edge = CPHA_BIT ? w_lead : w_trail;
  assign w_cs_fall    = ~w_cs_s & r_cs_d;
  assign w_cs_rise    = w_cs_s & ~r_cs_d;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_first     <= 1'b0;
      r_word_done <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_cnt   <= w_cnt_nxt;
      r_first     <= w_first_nxt;
      r_word_done <= w_word_done;
      r_underrun  <= w_underrun;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_bit_cnt;
    w_first_nxt = r_first;
    w_load      = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_first_nxt = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          // Deselect abandons the partial word silently.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (!CPHA_BIT) begin
          if (w_trail) begin
            if (r_bit_cnt == LAST_BIT) begin
              w_word_done = 1'b1;
              w_load      = 1'b1;
              w_cnt_nxt   = '0;
            end else begin
              w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
              w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
            end
          end
        end else begin
          if (w_lead) begin
            if (r_bit_cnt == '0) begin
              // First leading edge only consumes the MSB already on miso;
              // later ones present the MSB of a freshly loaded word.
              if (!r_first) w_load = 1'b1;
              w_first_nxt = 1'b0;
              w_cnt_nxt   = CNT_W'(1);
            end else begin
              w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
              w_cnt_nxt   = (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
            end
          end
          // bit_cnt back at 0 outside the first bit means bit 0 is showing.
          if (w_trail && (r_bit_cnt == '0) && !r_first) w_word_done = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) w_shift_nxt = w_fifo_empty ? IDLE_WORD : w_fifo_data;
  end

  // Loads look only at the registered empty flag, so a same-cycle push is
  // never forwarded into the shifter.
  assign w_pop      = w_load & ~w_fifo_empty;
  assign w_underrun = w_load & w_fifo_empty;

  assign miso      = r_shift[DATA_W-1];
  assign miso_oe   = ~w_cs_s;
  assign idle      = w_cs_s;
  assign word_done = r_word_done;
  assign underrun  = r_underrun;

`ifdef SPI_TX_EDGE_CNT_EN
  logic [23:0] r_trig_cnt;

  always_ff @(posedge clock) begin
    if (rst || w_cs_s) begin
      r_trig_cnt <= '0;
    end else if (w_shift_edge) begin
      r_trig_cnt <= r_trig_cnt + 24'd1;
    end
  end

  assign trigger_cnt = r_trig_cnt;
`endif

endmodule

// File: tb/tb_spi_tx_word_phy.sv
// tb/tb_spi_tx_word_phy.sv - directed self-checking bench, one DUT per SPI mode
module tb_spi_tx_word_phy;

  logic       clock = 1'b0;
  logic       rst;
  logic       sck_raw;
  logic [3:0] cs_n_v;
  logic [7:0] tx_data;
  logic [3:0] tx_valid_v;
  logic [3:0] miso_v, oe_v, rdy_v, wd_v, ur_v, idle_v;
  logic [2:0] lvl [4];
`ifdef SPI_TX_EDGE_CNT_EN
  logic [23:0] trig [4];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int wd_cnt [4];
  int ur_cnt [4];
  int lvl_max2;

  always #5 clock = ~clock;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      localparam int P_CPOL = g / 2;
      localparam int P_CPHA = g % 2;
      logic w_sck;
      assign w_sck = (P_CPOL != 0) ? ~sck_raw : sck_raw;
      spi_tx_word_phy #(
        .DATA_W (8),
        .DEPTH  (4),
        .CPOL   (P_CPOL),
        .CPHA   (P_CPHA)
      ) u_dut (
        .clock      (clock),
        .rst        (rst),
        .sck        (w_sck),
        .cs_n       (cs_n_v[g]),
        .miso       (miso_v[g]),
        .miso_oe    (oe_v[g]),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid_v[g]),
        .tx_ready   (rdy_v[g]),
        .fifo_level (lvl[g]),
        .word_done  (wd_v[g]),
        .underrun   (ur_v[g]),
        .idle       (idle_v[g])
`ifdef SPI_TX_EDGE_CNT_EN
        ,
        .trigger_cnt(trig[g])
`endif
      );
    end
  endgenerate

  initial begin
    for (int k = 0; k < 4; k++) begin
      wd_cnt[k] = 0;
      ur_cnt[k] = 0;
    end
    lvl_max2 = 0;
  end

  always @(negedge clock) begin
    for (int k = 0; k < 4; k++) begin
      if (wd_v[k] === 1'b1) wd_cnt[k] <= wd_cnt[k] + 1;
      if (ur_v[k] === 1'b1) ur_cnt[k] <= ur_cnt[k] + 1;
    end
    if (int'(lvl[2]) > lvl_max2) lvl_max2 <= int'(lvl[2]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int m, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clock);
    while (!rdy_v[m] && t < 50) begin
      @(negedge clock);
      t++;
    end
    chk("push_ready", 64'(rdy_v[m]), 64'd1);
    tx_data       = d;
    tx_valid_v[m] = 1'b1;
    @(negedge clock);
    tx_valid_v[m] = 1'b0;
  endtask

  task automatic select(input int m, input logic v);
    cs_n_v[m] = v;
    repeat (6) @(negedge clock);
  endtask

  // Master: sck_raw high = active level; samples right before the edge it
  // samples on (leading for CPHA=0, trailing for CPHA=1).
  task automatic run_sck(input int m, input int n, output logic [63:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      repeat (5) @(negedge clock);
      if (m % 2 == 0) bits = {bits[62:0], miso_v[m]};
      sck_raw = 1'b1;
      repeat (5) @(negedge clock);
      if (m % 2 == 1) bits = {bits[62:0], miso_v[m]};
      sck_raw = 1'b0;
    end
    repeat (6) @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] bits;
    int wd0, ur0, t;

    rst        = 1'b1;
    sck_raw    = 1'b0;
    cs_n_v     = 4'hF;
    tx_data    = 8'h00;
    tx_valid_v = 4'h0;
    repeat (4) @(negedge clock);
    chk("rst_miso",     64'(miso_v[0]), 64'd0);
    chk("rst_miso_oe",  64'(oe_v[0]),   64'd0);
    chk("rst_tx_ready", 64'(rdy_v[0]),  64'd1);
    chk("rst_level",    64'(lvl[0]),    64'd0);
    chk("rst_word_done",64'(wd_v[0]),   64'd0);
    chk("rst_underrun", 64'(ur_v[0]),   64'd0);
    chk("rst_idle",     64'(idle_v[0]), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clock);

    // MODE0 single word 0xA5
    wd0 = wd_cnt[0]; ur0 = ur_cnt[0];
    push(0, 8'hA5);
    chk("m0_level_after_push", 64'(lvl[0]), 64'd1);
    select(0, 1'b0);
    chk("m0_level_after_load", 64'(lvl[0]), 64'd0);
    chk("m0_msb_first",        64'(miso_v[0]), 64'd1);
    chk("m0_miso_oe",          64'(oe_v[0]), 64'd1);
    run_sck(0, 8, bits);
    chk("m0_rx_word",          bits[7:0], 64'hA5);
    chk("m0_word_done",        64'(wd_cnt[0] - wd0), 64'd1);
    chk("m0_underrun_reload",  64'(ur_cnt[0] - ur0), 64'd1);
`ifdef SPI_TX_EDGE_CNT_EN
    chk("m0_trigger_cnt",      64'(trig[0]), 64'd8);
`endif
    select(0, 1'b1);
    chk("m0_deselect_oe",      64'(oe_v[0]), 64'd0);
    chk("m0_deselect_idle",    64'(idle_v[0]), 64'd1);

    // MODE3 two words back to back
    wd0 = wd_cnt[3]; ur0 = ur_cnt[3];
    push(3, 8'h3C);
    push(3, 8'hC3);
    select(3, 1'b0);
    run_sck(3, 16, bits);
    chk("m3_rx_words",   bits[15:0], 64'h3CC3);
    chk("m3_word_done",  64'(wd_cnt[3] - wd0), 64'd2);
    chk("m3_no_underrun",64'(ur_cnt[3] - ur0), 64'd0);
    select(3, 1'b1);

    // MODE1 empty FIFO sends the idle word
    wd0 = wd_cnt[1]; ur0 = ur_cnt[1];
    select(1, 1'b0);
    chk("m1_underrun_at_select", 64'(ur_cnt[1] - ur0), 64'd1);
    run_sck(1, 8, bits);
    chk("m1_idle_word",     bits[7:0], 64'hFF);
    chk("m1_underrun_once", 64'(ur_cnt[1] - ur0), 64'd1);
    chk("m1_word_done",     64'(wd_cnt[1] - wd0), 64'd1);
    select(1, 1'b1);

    // MODE2 FIFO full, fifth word held until first pop
    push(2, 8'h11);
    push(2, 8'h22);
    push(2, 8'h33);
    push(2, 8'h44);
    chk("full_level", 64'(lvl[2]), 64'd4);
    chk("full_ready", 64'(rdy_v[2]), 64'd0);
    tx_data       = 8'h55;
    tx_valid_v[2] = 1'b1;
    repeat (5) @(negedge clock);
    chk("full_hold_level", 64'(lvl[2]), 64'd4);
    cs_n_v[2] = 1'b0;
    t = 0;
    while (!rdy_v[2] && t < 20) begin
      @(negedge clock);
      t++;
    end
    chk("full_accept_after_pop", 64'(rdy_v[2]), 64'd1);
    @(negedge clock);
    tx_valid_v[2] = 1'b0;
    repeat (2) @(negedge clock);
    chk("full_refill_level", 64'(lvl[2]), 64'd4);
    chk("full_level_max",    64'(lvl_max2), 64'd4);
    run_sck(2, 40, bits);
    chk("m2_word0", bits[39:32], 64'h11);
    chk("m2_word1", bits[31:24], 64'h22);
    chk("m2_word2", bits[23:16], 64'h33);
    chk("m2_word3", bits[15:8],  64'h44);
    chk("m2_word4", bits[7:0],   64'h55);
    chk("m2_drained", 64'(lvl[2]), 64'd0);
    select(2, 1'b1);

    // MODE0 abort after 3 bits, reselect starts fresh at the MSB
    wd0 = wd_cnt[0];
    push(0, 8'h81);
    push(0, 8'h42);
    select(0, 1'b0);
    run_sck(0, 3, bits);
    chk("abort_first_bits", bits[2:0], 64'h4);
    select(0, 1'b1);
    chk("abort_no_word_done", 64'(wd_cnt[0] - wd0), 64'd0);
    select(0, 1'b0);
    run_sck(0, 8, bits);
    chk("abort_next_word", bits[7:0], 64'h42);
    chk("abort_word_done", 64'(wd_cnt[0] - wd0), 64'd1);
    select(0, 1'b1);

    // MODE2 reset mid-word
    push(2, 8'hF0);
    push(2, 8'h0F);
    select(2, 1'b0);
    run_sck(2, 2, bits);
    chk("pre_rst_miso", 64'(miso_v[2]), 64'd1);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    chk("midrst_miso",  64'(miso_v[2]), 64'd0);
    chk("midrst_level", 64'(lvl[2]),    64'd0);
    chk("midrst_ready", 64'(rdy_v[2]),  64'd1);
`ifdef SPI_TX_EDGE_CNT_EN
    chk("midrst_trigger_cnt", 64'(trig[2]), 64'd0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clock);
    select(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
